// File: rtl/mask_index_serializer_pkg.sv
// mask_index_serializer_pkg: spin-mask sizing and types shared by the serializer files.
// Revision: 1.0
`default_nettype none

package mask_index_serializer_pkg;
  localparam int NUM_SPINS  = 8;
  localparam int SPIN_IDX_W = $clog2(NUM_SPINS);

  typedef logic [NUM_SPINS-1:0]  spin_mask_t;
  typedef logic [SPIN_IDX_W-1:0] spin_idx_t;
endpackage

`default_nettype wire

// File: rtl/mask_index_serializer_lsb_priority_enc.sv
// lsb_priority_enc: index of the lowest set bit of a mask, plus an any-bit-set flag.
// Revision: 1.0
`default_nettype none

module lsb_priority_enc #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDX_W-1:0] index,
  output logic             any_set
);

  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        index = IDX_W'(i);
      end
    end
  end

  assign any_set = |mask;

endmodule

`default_nettype wire

// File: rtl/mask_index_serializer.sv
// mask_index_serializer: accepts a spin mask and emits the indices of its set bits, lowest first.
// Revision: 1.0
`default_nettype none

module mask_index_serializer
  import mask_index_serializer_pkg::*;
#(
  parameter int NUM_SPINS = mask_index_serializer_pkg::NUM_SPINS,
  parameter int IDX_W     = $clog2(NUM_SPINS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 mask_valid,
  input  logic [NUM_SPINS-1:0] mask,
  output logic                 mask_ready,
  output logic                 idx_valid,
  output logic [IDX_W-1:0]     idx,
  output logic                 idx_last,
  input  logic                 idx_ready,
  output logic [IDX_W:0]       num_ones,
  output logic                 empty_pulse
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [NUM_SPINS-1:0] LSB_ONE = NUM_SPINS'(1);

  state_t               state;
  logic [NUM_SPINS-1:0] pending;
  logic [IDX_W-1:0]     enc_idx;
  logic                 enc_any;
  logic [IDX_W:0]       mask_ones;
  logic                 single_bit;

  lsb_priority_enc #(
    .WIDTH (NUM_SPINS),
    .IDX_W (IDX_W)
  ) u_lsb_enc (
    .mask    (pending),
    .index   (enc_idx),
    .any_set (enc_any)
  );

  always_comb begin
    mask_ones = '0;
    for (int i = 0; i < NUM_SPINS; i++) begin
      mask_ones = mask_ones + {{IDX_W{1'b0}}, mask[i]};
    end
  end

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign single_bit = enc_any && ((pending & (pending - LSB_ONE)) == '0);

  assign mask_ready = (state == IDLE);
  assign idx_valid  = (state == SCAN);
  assign idx        = enc_idx;
  assign idx_last   = idx_valid & single_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pending     <= '0;
      num_ones    <= '0;
      empty_pulse <= 1'b0;
    end else begin
      empty_pulse <= 1'b0;
      if (flush) begin
        state   <= IDLE;
        pending <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (mask_valid) begin
              num_ones <= mask_ones;
              if (|mask) begin
                pending <= mask;
                state   <= SCAN;
              end else begin
                empty_pulse <= 1'b1;
              end
            end
          end
          SCAN: begin
            if (idx_ready) begin
              pending <= pending & ~(LSB_ONE << enc_idx);
              if (single_bit) begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mask_index_serializer.sv
// tb_mask_index_serializer: directed self-checking bench for mask_index_serializer (NUM_SPINS=8).
// Revision: 1.0
`default_nettype none

module tb_mask_index_serializer;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       mask_valid;
  logic [7:0] mask;
  logic       mask_ready;
  logic       idx_valid;
  logic [2:0] idx;
  logic       idx_last;
  logic       idx_ready;
  logic [3:0] num_ones;
  logic       empty_pulse;

  int checks = 0;
  int errors = 0;

  mask_index_serializer #(
    .NUM_SPINS (8),
    .IDX_W     (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .mask_valid  (mask_valid),
    .mask        (mask),
    .mask_ready  (mask_ready),
    .idx_valid   (idx_valid),
    .idx         (idx),
    .idx_last    (idx_last),
    .idx_ready   (idx_ready),
    .num_ones    (num_ones),
    .empty_pulse (empty_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction

  // Checks every output against its idle value; tag names the scenario.
  task automatic check_idle(input string tag, input logic [3:0] exp_ones);
    checks++;
    if ({mask_ready, idx_valid, idx_last, empty_pulse} !== 4'b1000 || num_ones !== exp_ones) begin
      errors++;
      $display("FAIL %s: ready/valid/last/empty=%b%b%b%b num_ones=%0d, required 1000 num_ones=%0d",
               tag, mask_ready, idx_valid, idx_last, empty_pulse, num_ones, exp_ones);
    end
  endtask

  // Called at a negedge with the DUT idle; offers m and drains it using rdy_pat bit per cycle.
  task automatic run_mask(input string tag, input logic [7:0] m, input logic [31:0] rdy_pat);
    logic [7:0] rem;
    logic [2:0] exp_idx;
    int cyc;
    rem = m;
    cyc = 0;
    mask_valid = 1'b1;
    mask = m;
    idx_ready = 1'b0;
    @(negedge clk);
    mask_valid = 1'b0;
    checks++;
    if (num_ones !== 4'($countones(m))) begin
      errors++;
      $display("FAIL %s num_ones: got %0d, required %0d", tag, num_ones, $countones(m));
    end
    while (rem != 8'h00 && cyc < 64) begin
      exp_idx = lowest_bit(rem);
      checks++;
      if (idx_valid !== 1'b1 || idx !== exp_idx || idx_last !== ($countones(rem) == 1) || mask_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s emit cyc%0d: valid=%b idx=%0d last=%b ready=%b, required 1 %0d %b 0",
                 tag, cyc, idx_valid, idx, idx_last, mask_ready, exp_idx, ($countones(rem) == 1));
      end
      idx_ready = rdy_pat[cyc % 32];
      if (idx_ready) rem = rem & ~(8'h01 << exp_idx);
      @(negedge clk);
      cyc++;
    end
    idx_ready = 1'b0;
    if (cyc >= 64) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d indices still pending", tag, $countones(rem));
    end
    if (m != 8'h00) check_idle({tag, " end"}, 4'($countones(m)));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    flush = 1'b0;
    mask_valid = 1'b0;
    mask = 8'h00;
    idx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset", 4'd0);
    checks++;
    if (idx !== 3'd0) begin
      errors++;
      $display("FAIL reset idx: got %0d, required 0", idx);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sparse();
    run_mask("sparse_a4", 8'b1010_0100, 32'hFFFF_FFFF);
  endtask

  task automatic test_empty();
    mask_valid = 1'b1;
    mask = 8'h00;
    @(negedge clk);
    mask_valid = 1'b0;
    checks++;
    if (empty_pulse !== 1'b1 || idx_valid !== 1'b0 || mask_ready !== 1'b1 || num_ones !== 4'd0) begin
      errors++;
      $display("FAIL empty pulse: empty=%b valid=%b ready=%b num_ones=%0d, required 1 0 1 0",
               empty_pulse, idx_valid, mask_ready, num_ones);
    end
    @(negedge clk);
    check_idle("empty after", 4'd0);
  endtask

  task automatic test_backpressure();
    run_mask("stall_12", 8'b0001_0010, 32'hFFFF_FFF8);
  endtask

  task automatic test_busy_ignore();
    mask_valid = 1'b1;
    mask = 8'h03;
    @(negedge clk);
    mask = 8'hF0;
    repeat (2) @(negedge clk);
    checks++;
    if (idx_valid !== 1'b1 || idx !== 3'd0 || num_ones !== 4'd2 || idx_last !== 1'b0) begin
      errors++;
      $display("FAIL busy ignore: valid=%b idx=%0d num_ones=%0d last=%b, required 1 0 2 0",
               idx_valid, idx, num_ones, idx_last);
    end
    mask_valid = 1'b0;
    idx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (idx !== 3'd1 || idx_last !== 1'b1) begin
      errors++;
      $display("FAIL busy second: idx=%0d last=%b, required 1 1", idx, idx_last);
    end
    @(negedge clk);
    idx_ready = 1'b0;
    check_idle("busy end", 4'd2);
    @(negedge clk);
    check_idle("busy no stray", 4'd2);
  endtask

  task automatic test_flush();
    mask_valid = 1'b1;
    mask = 8'hFF;
    idx_ready = 1'b1;
    @(negedge clk);
    mask_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (idx !== 3'd3 || idx_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush pre: idx=%0d valid=%b, required 3 1", idx, idx_valid);
    end
    flush = 1'b1;
    @(negedge clk);
    check_idle("flush", 4'd8);
    mask_valid = 1'b1;
    mask = 8'h0F;
    @(negedge clk);
    check_idle("flush blocks accept", 4'd8);
    flush = 1'b0;
    mask_valid = 1'b0;
    idx_ready = 1'b0;
    @(negedge clk);
    check_idle("flush settled", 4'd8);
  endtask

  task automatic test_async_reset();
    mask_valid = 1'b1;
    mask = 8'h81;
    idx_ready = 1'b1;
    @(negedge clk);
    mask_valid = 1'b0;
    @(negedge clk);
    idx_ready = 1'b0;
    checks++;
    if (idx !== 3'd7 || idx_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst pre: idx=%0d valid=%b, required 7 1", idx, idx_valid);
    end
    #2 reset = 1'b0;
    #1;
    check_idle("async reset", 4'd0);
    checks++;
    if (idx !== 3'd0) begin
      errors++;
      $display("FAIL async reset idx: got %0d, required 0", idx);
    end
    @(negedge clk);
    reset = 1'b1;
    idx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (idx_valid !== 1'b0) begin
        errors++;
        $display("FAIL post reset cyc%0d: idx_valid=%b idx=%0d, required valid 0", i, idx_valid, idx);
      end
    end
    idx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  masks [6] = '{8'hFF, 8'h80, 8'h01, 8'h5A, 8'hC3, 8'h24};
    logic [31:0] pats  [6] = '{32'hFFFF_FFFF, 32'h0000_0006, 32'h5555_5555,
                               32'h3333_3333, 32'hA5A5_A5A5, 32'hFFFF_FFFE};
    for (int i = 0; i < 6; i++) begin
      run_mask($sformatf("b2b%0d", i), masks[i], pats[i]);
    end
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_empty();
    test_backpressure();
    test_busy_ignore();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mask_index_serializer.md
MASK_INDEX_SERIALIZER -- requirements
Module: mask_index_serializer

Interface
REQ-001 Parameter: NUM_SPINS, default from common package (8 in unit bench); width of spin mask.
REQ-002 Parameter: IDX_W, default $clog2(NUM_SPINS); width of emitted spin index.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous abort of current mask.
REQ-006 mask_valid  input  1  upstream mask offered.
REQ-007 mask  input  NUM_SPINS  spin mask, bit i set = spin i selected.
REQ-008 mask_ready  output  1  block accepts mask this cycle.
REQ-009 idx_valid  output  1  idx holds a valid spin index.
REQ-010 idx  output  IDX_W  index of lowest remaining set bit.
REQ-011 idx_last  output  1  current idx is final index of the mask.
REQ-012 idx_ready  input  1  downstream consumes idx this cycle.
REQ-013 num_ones  output  IDX_W+1  popcount of the accepted mask.
REQ-014 empty_pulse  output  1  one-cycle pulse: accepted mask was all-zero.

Function
REQ-015 FSM states SHALL be IDLE and SCAN only.
REQ-016 mask_ready SHALL equal (state==IDLE) and SHALL be independent of mask_valid.
REQ-017 Mask accept = mask_valid & mask_ready & ~flush; on accept the mask SHALL load into pending register and num_ones SHALL load $countones(mask).
REQ-018 Accept of nonzero mask SHALL move IDLE->SCAN; idx_valid SHALL first assert the next cycle (1-cycle latency).
REQ-019 Accept of zero mask SHALL keep IDLE, set num_ones=0, and assert empty_pulse for exactly the next cycle.
REQ-020 In SCAN, idx_valid SHALL be 1 and idx SHALL be lowest set bit index of pending.
REQ-021 idx_last SHALL be 1 iff pending has exactly one set bit; 0 whenever idx_valid=0.
REQ-022 idx and idx_last SHALL hold stable while idx_valid & ~idx_ready.
REQ-023 On idx_valid & idx_ready, the emitted bit SHALL clear from pending the same edge.
REQ-024 Handshake with idx_last=1 SHALL move SCAN->IDLE; mask_ready asserts the following cycle (one bubble between masks).
REQ-025 Indices SHALL emit strictly ascending; count of handshakes per mask SHALL equal num_ones.
REQ-026 num_ones SHALL hold its value until the next accept or reset.
REQ-027 flush=1 SHALL force IDLE and clear pending next edge, overriding any concurrent handshake or accept; num_ones unchanged.
REQ-028 mask_valid while mask_ready=0 SHALL be ignored with no state change.
REQ-029 All-ones mask SHALL emit 0..NUM_SPINS-1, idx_last on NUM_SPINS-1.

Reset
REQ-030 reset low SHALL immediately force: state=IDLE, pending=0, num_ones=0, idx_valid=0, idx=0, idx_last=0, empty_pulse=0, mask_ready=1.
REQ-031 Reset asserted mid-SCAN SHALL discard the remaining indices; no index emits after release until a new accept.

Structure
REQ-032 NUM_SPINS, derived SPIN_IDX_W, and typedefs spin_mask_t / spin_idx_t SHALL live in the shared common package.
REQ-033 FSM state enum SHALL be local to the module.
REQ-034 The lowest-set-bit encoder SHALL be one combinational sub-module, lsb_priority_enc (mask in; index and any-set out).

Verification (NUM_SPINS=8)
REQ-035 Accept 8'b1010_0100, idx_ready=1 -> idx 2,5,7 on consecutive cycles from accept+1, idx_last on 7, num_ones=3, mask_ready high cycle after 7.
REQ-036 Accept 8'h00 -> empty_pulse high exactly one cycle, idx_valid never high, num_ones=0, mask_ready stays 1.
REQ-037 Accept 8'b0001_0010, idx_ready low 3 cycles then high -> idx=1 held stable 3 cycles, then 1,4 emitted, idx_last only with 4.
REQ-038 Accept 8'hFF, flush asserted with handshake of idx=3 -> next cycle IDLE, idx_valid=0, mask_ready=1, num_ones=8.
REQ-039 Accept 8'h81, drop reset after idx=0 handshake -> all outputs at reset values asynchronously, idx 7 never emitted.
REQ-040 Random masks x1000 with random idx_ready -> emitted index set equals mask bits, ascending, count equals num_ones.
